// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared types and defaults for the pipeline hazard sequencer.
//   - hz_state_t   : sequencer FSM states
//   - stage_ctrl_t : enable/flush pair for one pipeline register
//   - REG_W_DEFAULT, CNT_W_DEFAULT : default widths
package hazard_pkg;

  localparam int REG_W_DEFAULT = 5;
  localparam int CNT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    DDONE  = 2'd2,
    HALTED = 2'd3
  } hz_state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect
//   Combinational load-use comparator. Flags when the load sitting in ID/EX
//   writes a register the IF/ID instruction reads. Register 0 is hardwired
//   to zero, so a load targeting it never creates a dependency.
// Ports:
//   dx_dREN     in  ID/EX instr is a load
//   dx_wsel     in  ID/EX destination register
//   fd_rs/fd_rt in  IF/ID source registers
//   fd_uses_rt  in  IF/ID instr reads rt
//   load_use    out hazard detected
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEFAULT
) (
  input  logic             dx_dREN,
  input  logic [REG_W-1:0] dx_wsel,
  input  logic [REG_W-1:0] fd_rs,
  input  logic [REG_W-1:0] fd_rt,
  input  logic             fd_uses_rt,
  output logic             load_use
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (dx_wsel == fd_rs);
  assign rt_match = fd_uses_rt & (dx_wsel == fd_rt);
  assign load_use = dx_dREN & (dx_wsel != '0) & (rs_match | rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central sequencer for the PC and the IF/ID, ID/EX, EX/MEM, MEM/WB pipeline
//   registers. Derives per-stage enable/flush from cache hits, load-use
//   hazards, control redirects and halt; remembers a completed data access
//   (DDONE) so it is not re-requested while the I-side is still stalled;
//   latches halt until reset.
//   Optional macro HAZARD_PERF_EN adds wrapping stall/bubble/flush counters.
// Ports:
//   CLK, RST (async, active-high)
//   ihit, dhit                       cache hits this cycle
//   fd_rs, fd_rt, fd_uses_rt         IF/ID source operands
//   dx_dREN, dx_wsel                 ID/EX load and destination
//   xm_dREN, xm_dWEN, xm_redirect, xm_halt   EX/MEM status
//   pc_en, {fd,dx,xm,mw}_en/_flush   pipeline control (flush beats enable)
//   dmem_req                         gated data-cache request
//   halted                           sticky halt
//   stall_cnt, bubble_cnt, flush_cnt (HAZARD_PERF_EN only)
// All outputs are combinational from state and inputs, and forced to 0
// while RST is high.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEFAULT
`ifdef HAZARD_PERF_EN
  ,
  parameter int CNT_W = CNT_W_DEFAULT
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [REG_W-1:0] fd_rs,
  input  logic [REG_W-1:0] fd_rt,
  input  logic             fd_uses_rt,
  input  logic             dx_dREN,
  input  logic [REG_W-1:0] dx_wsel,
  input  logic             xm_dREN,
  input  logic             xm_dWEN,
  input  logic             xm_redirect,
  input  logic             xm_halt,
  output logic             pc_en,
  output logic             fd_en,
  output logic             dx_en,
  output logic             xm_en,
  output logic             mw_en,
  output logic             fd_flush,
  output logic             dx_flush,
  output logic             xm_flush,
  output logic             mw_flush,
  output logic             dmem_req,
  output logic             halted
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  hz_state_t   state_reg;
  hz_state_t   state_next;

  logic        mem_op;
  logic        done_q;
  logic        in_halted;
  logic        mem_ok;
  logic        adv;
  logic        load_use;

  logic        pc_c;
  stage_ctrl_t fd_c;
  stage_ctrl_t dx_c;
  stage_ctrl_t xm_c;
  stage_ctrl_t mw_c;

  hazard_detect #(
    .REG_W (REG_W)
  ) u_detect (
    .dx_dREN    (dx_dREN),
    .dx_wsel    (dx_wsel),
    .fd_rs      (fd_rs),
    .fd_rt      (fd_rt),
    .fd_uses_rt (fd_uses_rt),
    .load_use   (load_use)
  );

  assign mem_op    = xm_dREN | xm_dWEN;
  assign done_q    = (state_reg == DDONE);
  assign in_halted = (state_reg == HALTED);
  // In DDONE the data side already finished, so only the I-side gates advance.
  assign mem_ok    = ~mem_op | dhit | done_q;
  assign adv       = ihit & mem_ok & ~in_halted;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN, DWAIT: begin
        if (adv) begin
          state_next = xm_halt ? HALTED : RUN;
        end else if (mem_op & dhit) begin
          // data finished but the I-side is stalled: remember it
          state_next = DDONE;
        end else if (mem_op) begin
          state_next = DWAIT;
        end else begin
          state_next = RUN;
        end
      end
      DDONE: begin
        if (adv) begin
          state_next = xm_halt ? HALTED : RUN;
        end
      end
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  // Stage control. Priority: halt > redirect > load-use > normal advance.
  // Without adv every register holds (all zero).
  always_comb begin
    pc_c = 1'b0;
    fd_c = '0;
    dx_c = '0;
    xm_c = '0;
    mw_c = '0;
    if (adv) begin
      if (xm_halt) begin
        // halt retires into MEM/WB; younger work is frozen, EX/MEM cleared
        mw_c.en    = 1'b1;
        xm_c.flush = 1'b1;
      end else if (xm_redirect) begin
        // younger instrs (including any load-use victim) are squashed
        pc_c = 1'b1;
        fd_c = '{en: 1'b1, flush: 1'b1};
        dx_c = '{en: 1'b1, flush: 1'b1};
        xm_c = '{en: 1'b1, flush: 1'b1};
        mw_c.en = 1'b1;
      end else if (load_use) begin
        // hold PC and IF/ID, inject a bubble into ID/EX
        dx_c    = '{en: 1'b1, flush: 1'b1};
        xm_c.en = 1'b1;
        mw_c.en = 1'b1;
      end else begin
        pc_c    = 1'b1;
        fd_c.en = 1'b1;
        dx_c.en = 1'b1;
        xm_c.en = 1'b1;
        mw_c.en = 1'b1;
      end
    end
  end

  assign pc_en    = ~RST & pc_c;
  assign fd_en    = ~RST & fd_c.en;
  assign dx_en    = ~RST & dx_c.en;
  assign xm_en    = ~RST & xm_c.en;
  assign mw_en    = ~RST & mw_c.en;
  assign fd_flush = ~RST & fd_c.flush;
  assign dx_flush = ~RST & dx_c.flush;
  assign xm_flush = ~RST & xm_c.flush;
  assign mw_flush = ~RST & mw_c.flush;
  assign dmem_req = ~RST & mem_op & ~done_q & ~in_halted;
  assign halted   = ~RST & in_halted;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] bubble_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;
  logic             bubble_ev;
  logic             redirect_ev;

  assign bubble_ev   = adv & ~xm_halt & ~xm_redirect & load_use;
  assign redirect_ev = adv & ~xm_halt & xm_redirect;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_reg  <= '0;
      bubble_cnt_reg <= '0;
      flush_cnt_reg  <= '0;
    end else if (!in_halted) begin
      if (!adv) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      if (bubble_ev) begin
        bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
      end
      if (redirect_ev) begin
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
      end
    end
  end

  assign stall_cnt  = stall_cnt_reg;
  assign bubble_cnt = bubble_cnt_reg;
  assign flush_cnt  = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Table-driven bench for pipe_hazard_ctrl. Each entry drives one cycle of
//   inputs; the required output vector is queued with the stimulus and
//   compared when the outputs settle (negative clock edge).
//   Output vector bit order:
//   {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush,
//    mw_flush, dmem_req, halted}
module tb_pipe_hazard_ctrl;

  logic       CLK;
  logic       RST;
  logic       ihit, dhit;
  logic [4:0] fd_rs, fd_rt, dx_wsel;
  logic       fd_uses_rt, dx_dREN;
  logic       xm_dREN, xm_dWEN, xm_redirect, xm_halt;
  logic       pc_en, fd_en, dx_en, xm_en, mw_en;
  logic       fd_flush, dx_flush, xm_flush, mw_flush;
  logic       dmem_req, halted;
`ifdef HAZARD_PERF_EN
  logic [2:0] stall_cnt, bubble_cnt, flush_cnt;
`endif

  pipe_hazard_ctrl #(
    .REG_W (5)
`ifdef HAZARD_PERF_EN
    ,
    .CNT_W (3)
`endif
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ihit        (ihit),
    .dhit        (dhit),
    .fd_rs       (fd_rs),
    .fd_rt       (fd_rt),
    .fd_uses_rt  (fd_uses_rt),
    .dx_dREN     (dx_dREN),
    .dx_wsel     (dx_wsel),
    .xm_dREN     (xm_dREN),
    .xm_dWEN     (xm_dWEN),
    .xm_redirect (xm_redirect),
    .xm_halt     (xm_halt),
    .pc_en       (pc_en),
    .fd_en       (fd_en),
    .dx_en       (dx_en),
    .xm_en       (xm_en),
    .mw_en       (mw_en),
    .fd_flush    (fd_flush),
    .dx_flush    (dx_flush),
    .xm_flush    (xm_flush),
    .mw_flush    (mw_flush),
    .dmem_req    (dmem_req),
    .halted      (halted)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .bubble_cnt  (bubble_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // required output patterns
  localparam logic [10:0] ALL   = 11'b11111111111;
  localparam logic [10:0] HOLD  = 11'b00000000000;
  localparam logic [10:0] HOLDR = 11'b00000000010; // hold, request pending
  localparam logic [10:0] NORM  = 11'b11111000000;
  localparam logic [10:0] NORMR = 11'b11111000010;
  localparam logic [10:0] BUB   = 11'b00111010000; // pc/fd held, dx flushed
  localparam logic [10:0] BUBM  = 11'b11011111111; // dx_en don't-care
  localparam logic [10:0] RDR   = 11'b10001111000; // fd/dx/xm flushed
  localparam logic [10:0] RDRM  = 11'b10001111111; // fd/dx/xm_en don't-care
  localparam logic [10:0] HLT   = 11'b00001001000; // mw_en + xm_flush
  localparam logic [10:0] HALTD = 11'b00000000001;

  // ctl = {rst, ihit, dhit, xm_dREN, xm_dWEN, xm_redirect, xm_halt, dx_dREN}
  typedef struct {
    logic [7:0]  ctl;
    logic [4:0]  wsel, rs, rt;
    logic        urt;
    logic [10:0] exp, mask;
  } stim_t;

  stim_t       sb_q[$];
  stim_t       e;
  logic [10:0] obs;
  int          total = 0;
  int          bad   = 0;

  function automatic stim_t mk(input logic [7:0] ctl, input logic [4:0] wsel,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic urt, input logic [10:0] exp,
                               input logic [10:0] mask);
    stim_t s;
    s.ctl = ctl; s.wsel = wsel; s.rs = rs; s.rt = rt; s.urt = urt;
    s.exp = exp; s.mask = mask;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    {RST, ihit, dhit, xm_dREN, xm_dWEN, xm_redirect, xm_halt, dx_dREN} = s.ctl;
    dx_wsel = s.wsel; fd_rs = s.rs; fd_rt = s.rt; fd_uses_rt = s.urt;
  endtask

  // inputs are applied #1 after posedge; outputs sampled at the negedge
  task automatic sample_step();
    @(negedge CLK);
    obs = {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush,
           mw_flush, dmem_req, halted};
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    stim_t t[$];
    t.push_back(mk(8'b11110111, 8, 8, 0, 0, HOLD, ALL)); // outputs dead in reset
    t.push_back(mk(8'b01000000, 0, 0, 0, 0, NORM, ALL)); // RUN after release
    foreach (t[i]) begin
      apply(t[i]); sb_q.push_back(t[i]); sample_step(); e = sb_q.pop_front();
      total++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        bad++;
        $display("FAIL reset[%0d]: got %b required %b", i, obs & e.mask, e.exp & e.mask);
      end
    end
  endtask

  task automatic test_dwait();
    stim_t t[$];
    repeat (3) t.push_back(mk(8'b01010000, 0, 0, 0, 0, HOLDR, ALL)); // load miss
    t.push_back(mk(8'b01110000, 0, 0, 0, 0, NORMR, ALL));            // dhit
    t.push_back(mk(8'b01000000, 0, 0, 0, 0, NORM, ALL));
    t.push_back(mk(8'b01001000, 0, 0, 0, 0, HOLDR, ALL));            // store miss
    t.push_back(mk(8'b01101000, 0, 0, 0, 0, NORMR, ALL));
    foreach (t[i]) begin
      apply(t[i]); sb_q.push_back(t[i]); sample_step(); e = sb_q.pop_front();
      total++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        bad++;
        $display("FAIL dwait[%0d]: got %b required %b", i, obs & e.mask, e.exp & e.mask);
      end
    end
  endtask

  task automatic test_ddone();
    stim_t t[$];
    t.push_back(mk(8'b00110000, 0, 0, 0, 0, HOLDR, ALL)); // dhit, no ihit
    t.push_back(mk(8'b00010000, 0, 0, 0, 0, HOLD, ALL));  // DDONE: no re-request
    t.push_back(mk(8'b00010000, 0, 0, 0, 0, HOLD, ALL));
    t.push_back(mk(8'b01010000, 0, 0, 0, 0, NORM, ALL));  // ihit -> advance
    t.push_back(mk(8'b01000000, 0, 0, 0, 0, NORM, ALL));
    t.push_back(mk(8'b00100000, 0, 0, 0, 0, HOLD, ALL));  // stray dhit ignored
    t.push_back(mk(8'b01010000, 0, 0, 0, 0, HOLDR, ALL)); // still requesting
    t.push_back(mk(8'b01110000, 0, 0, 0, 0, NORMR, ALL));
    t.push_back(mk(8'b00110000, 0, 0, 0, 0, HOLDR, ALL)); // into DDONE
    t.push_back(mk(8'b11010000, 0, 0, 0, 0, HOLD, ALL));  // reset mid-op
    t.push_back(mk(8'b01010000, 0, 0, 0, 0, HOLDR, ALL)); // request reissued
    t.push_back(mk(8'b01110000, 0, 0, 0, 0, NORMR, ALL));
    foreach (t[i]) begin
      apply(t[i]); sb_q.push_back(t[i]); sample_step(); e = sb_q.pop_front();
      total++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        bad++;
        $display("FAIL ddone[%0d]: got %b required %b", i, obs & e.mask, e.exp & e.mask);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t t[$];
    t.push_back(mk(8'b01000001, 8, 8, 0, 0, BUB, BUBM));  // rs match
    t.push_back(mk(8'b01000000, 8, 8, 0, 0, NORM, ALL));  // bubble now in ID/EX
    t.push_back(mk(8'b01000001, 8, 3, 8, 1, BUB, BUBM));  // rt match
    t.push_back(mk(8'b01000001, 8, 3, 8, 0, NORM, ALL));  // rt not read
    t.push_back(mk(8'b01000001, 0, 0, 0, 1, NORM, ALL));  // $0 never hazards
    t.push_back(mk(8'b01000000, 8, 8, 8, 1, NORM, ALL));  // not a load
    t.push_back(mk(8'b00000001, 8, 8, 0, 0, HOLD, ALL));  // icache miss wins
    t.push_back(mk(8'b01010001, 8, 8, 0, 0, HOLDR, ALL)); // dcache miss wins
    t.push_back(mk(8'b01110001, 8, 8, 0, 0, BUB | 11'b10, BUBM));
    foreach (t[i]) begin
      apply(t[i]); sb_q.push_back(t[i]); sample_step(); e = sb_q.pop_front();
      total++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        bad++;
        $display("FAIL load_use[%0d]: got %b required %b", i, obs & e.mask, e.exp & e.mask);
      end
    end
  endtask

  task automatic test_redirect();
    stim_t t[$];
    t.push_back(mk(8'b01000101, 8, 8, 0, 0, RDR, RDRM)); // beats load-use
    t.push_back(mk(8'b01000100, 0, 0, 0, 0, RDR, RDRM));
    t.push_back(mk(8'b00000100, 0, 0, 0, 0, HOLD, ALL));
    t.push_back(mk(8'b01000000, 0, 0, 0, 0, NORM, ALL));
    foreach (t[i]) begin
      apply(t[i]); sb_q.push_back(t[i]); sample_step(); e = sb_q.pop_front();
      total++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        bad++;
        $display("FAIL redirect[%0d]: got %b required %b", i, obs & e.mask, e.exp & e.mask);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t t[$];
    t.push_back(mk(8'b01000001, 9, 9, 0, 0, BUB, BUBM));
    t.push_back(mk(8'b01000001, 4, 1, 4, 1, BUB, BUBM));
    t.push_back(mk(8'b01000100, 0, 0, 0, 0, RDR, RDRM));
    t.push_back(mk(8'b01000001, 7, 7, 0, 0, BUB, BUBM));
    t.push_back(mk(8'b01000000, 0, 0, 0, 0, NORM, ALL));
    foreach (t[i]) begin
      apply(t[i]); sb_q.push_back(t[i]); sample_step(); e = sb_q.pop_front();
      total++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        bad++;
        $display("FAIL back_to_back[%0d]: got %b required %b", i, obs & e.mask, e.exp & e.mask);
      end
    end
  endtask

  task automatic test_halt();
    stim_t t[$];
    t.push_back(mk(8'b00000010, 0, 0, 0, 0, HOLD, ALL));  // halt but no ihit
    t.push_back(mk(8'b01000111, 8, 8, 0, 0, HLT, ALL));   // beats redirect/load-use
    t.push_back(mk(8'b01000000, 0, 0, 0, 0, HALTD, ALL));
    t.push_back(mk(8'b01010000, 0, 0, 0, 0, HALTD, ALL)); // no dmem_req
    t.push_back(mk(8'b01100100, 0, 0, 0, 0, HALTD, ALL));
    t.push_back(mk(8'b11000000, 0, 0, 0, 0, HOLD, ALL));  // reset clears halt
    t.push_back(mk(8'b01000000, 0, 0, 0, 0, NORM, ALL));
    t.push_back(mk(8'b01000010, 0, 0, 0, 0, HLT, ALL));   // plain halt
    t.push_back(mk(8'b00000000, 0, 0, 0, 0, HALTD, ALL));
    t.push_back(mk(8'b11000000, 0, 0, 0, 0, HOLD, ALL));
    t.push_back(mk(8'b01000000, 0, 0, 0, 0, NORM, ALL));
    foreach (t[i]) begin
      apply(t[i]); sb_q.push_back(t[i]); sample_step(); e = sb_q.pop_front();
      total++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        bad++;
        $display("FAIL halt[%0d]: got %b required %b", i, obs & e.mask, e.exp & e.mask);
      end
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    stim_t t[$];
    t.push_back(mk(8'b11000000, 0, 0, 0, 0, HOLD, ALL));
    t.push_back(mk(8'b01000000, 0, 0, 0, 0, NORM, ALL));
    repeat (5) t.push_back(mk(8'b00000000, 0, 0, 0, 0, HOLD, ALL));
    t.push_back(mk(8'b01000001, 8, 8, 0, 0, BUB, BUBM));
    t.push_back(mk(8'b01000001, 5, 5, 0, 0, BUB, BUBM));
    t.push_back(mk(8'b01000100, 0, 0, 0, 0, RDR, RDRM));
    foreach (t[i]) begin
      apply(t[i]); sb_q.push_back(t[i]); sample_step(); e = sb_q.pop_front();
      total++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        bad++;
        $display("FAIL perf[%0d]: got %b required %b", i, obs & e.mask, e.exp & e.mask);
      end
    end
    total++;
    if ({stall_cnt, bubble_cnt, flush_cnt} !== {3'd5, 3'd2, 3'd1}) begin
      bad++;
      $display("FAIL perf_counts: got %0d/%0d/%0d required 5/2/1", stall_cnt, bubble_cnt, flush_cnt);
    end
    // 3 more stalls: 3-bit counter 5 -> 0 (wrap)
    apply(mk(8'b00000000, 0, 0, 0, 0, HOLD, ALL));
    repeat (3) sample_step();
    total++;
    if (stall_cnt !== 3'd0) begin
      bad++;
      $display("FAIL perf_wrap: got %0d required 0", stall_cnt);
    end
    // counters freeze once halted
    apply(mk(8'b01000010, 0, 0, 0, 0, HLT, ALL));
    sample_step();
    apply(mk(8'b00000000, 0, 0, 0, 0, HALTD, ALL));
    repeat (2) sample_step();
    total++;
    if ({stall_cnt, bubble_cnt, flush_cnt} !== {3'd0, 3'd2, 3'd1}) begin
      bad++;
      $display("FAIL perf_freeze: got %0d/%0d/%0d required 0/2/1", stall_cnt, bubble_cnt, flush_cnt);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b0; ihit = 1'b0; dhit = 1'b0; fd_rs = '0; fd_rt = '0; dx_wsel = '0;
    fd_uses_rt = 1'b0; dx_dREN = 1'b0; xm_dREN = 1'b0; xm_dWEN = 1'b0;
    xm_redirect = 1'b0; xm_halt = 1'b0;
    #2 RST = 1'b1;
    @(posedge CLK);
    #1;
    test_reset();
    test_dwait();
    test_ddone();
    test_load_use();
    test_redirect();
    test_back_to_back();
    test_halt();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
